// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_pkg
//  Description : Opcodes, step encodings and control-word masks for the
//                8-bit bus CPU control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        STEP_T0 = 3'd0,
        STEP_T1 = 3'd1,
        STEP_T2 = 3'd2,
        STEP_T3 = 3'd3,
        STEP_T4 = 3'd4
    } step_t;

    // Control word is active-high internally; the top inverts the *_n strobes.
    localparam int CW_W = 15;
    typedef logic [CW_W-1:0] ctrl_word_t;

    localparam ctrl_word_t CW_NONE      = 15'h0000;
    localparam ctrl_word_t CW_PC_OUT    = 15'h0001;
    localparam ctrl_word_t CW_PC_INC    = 15'h0002;
    localparam ctrl_word_t CW_PC_LOAD   = 15'h0004;
    localparam ctrl_word_t CW_MAR_IN    = 15'h0008;
    localparam ctrl_word_t CW_RAM_OUT   = 15'h0010;
    localparam ctrl_word_t CW_RAM_IN    = 15'h0020;
    localparam ctrl_word_t CW_IR_IN     = 15'h0040;
    localparam ctrl_word_t CW_IR_OUT    = 15'h0080;
    localparam ctrl_word_t CW_A_IN      = 15'h0100;
    localparam ctrl_word_t CW_A_OUT     = 15'h0200;
    localparam ctrl_word_t CW_B_IN      = 15'h0400;
    localparam ctrl_word_t CW_OUT_IN    = 15'h0800;
    localparam ctrl_word_t CW_ALU_READ  = 15'h1000;
    localparam ctrl_word_t CW_ALU_SUB   = 15'h2000;
    localparam ctrl_word_t CW_ALU_FLAGS = 15'h4000;

    function automatic logic cw_has(input ctrl_word_t cw, input ctrl_word_t mask);
        return |(cw & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Inputs and control strobes between the sequencer and the
//                CPU datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              i_step_en;
    logic [DATA_W-1:0] i_instr;
    logic              i_flag_c;
    logic              i_flag_z;

    logic              o_pc_out_n;
    logic              o_pc_inc;
    logic              o_pc_load_n;
    logic              o_mar_in_n;
    logic              o_ram_out_n;
    logic              o_ram_in_n;
    logic              o_ir_in_n;
    logic              o_ir_out_n;
    logic              o_a_in_n;
    logic              o_a_out_n;
    logic              o_b_in_n;
    logic              o_out_in_n;
    logic              o_alu_read_n;
    logic              o_alu_sub;
    logic              o_alu_flags_n;
    logic              o_flag_c;
    logic              o_flag_z;
    logic              o_halt;
    logic [2:0]        o_step;

    modport master (
        input  i_step_en, i_instr, i_flag_c, i_flag_z,
        output o_pc_out_n, o_pc_inc, o_pc_load_n, o_mar_in_n, o_ram_out_n,
               o_ram_in_n, o_ir_in_n, o_ir_out_n, o_a_in_n, o_a_out_n,
               o_b_in_n, o_out_in_n, o_alu_read_n, o_alu_sub, o_alu_flags_n,
               o_flag_c, o_flag_z, o_halt, o_step
    );

    modport slave (
        output i_step_en, i_instr, i_flag_c, i_flag_z,
        input  o_pc_out_n, o_pc_inc, o_pc_load_n, o_mar_in_n, o_ram_out_n,
               o_ram_in_n, o_ir_in_n, o_ir_out_n, o_a_in_n, o_a_out_n,
               o_b_in_n, o_out_in_n, o_alu_read_n, o_alu_sub, o_alu_flags_n,
               o_flag_c, o_flag_z, o_halt, o_step
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_microcode_rom.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_microcode_rom
//  Description : Combinational microcode: (opcode, step, C, Z) -> control
//                word, last-step, halt request and flag write enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer_microcode_rom
    import control_sequencer_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  wire logic [OPCODE_W-1:0] i_opcode,
    input  wire logic [2:0]          i_step,
    input  wire logic                i_flag_c,
    input  wire logic                i_flag_z,
    output ctrl_word_t               o_ctrl,
    output logic                     o_last_step,
    output logic                     o_halt_req,
    output logic                     o_flag_we
);

    always_comb begin
        o_ctrl      = CW_NONE;
        o_last_step = 1'b0;
        o_halt_req  = 1'b0;
        o_flag_we   = 1'b0;
        case (i_step)
            STEP_T0: o_ctrl = CW_PC_OUT | CW_MAR_IN;
            STEP_T1: begin
                o_ctrl = CW_RAM_OUT | CW_IR_IN | CW_PC_INC;
                // Opcodes without an execute phase (NOP and 9..D) finish here.
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP,
                    OP_JC, OP_JZ, OP_OUT, OP_HLT: o_last_step = 1'b0;
                    default:                      o_last_step = 1'b1;
                endcase
            end
            STEP_T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: o_ctrl = CW_IR_OUT | CW_MAR_IN;
                    OP_LDI: begin
                        o_ctrl      = CW_IR_OUT | CW_A_IN;
                        o_last_step = 1'b1;
                    end
                    OP_JMP: begin
                        o_ctrl      = CW_IR_OUT | CW_PC_LOAD;
                        o_last_step = 1'b1;
                    end
                    OP_JC: begin
                        o_ctrl      = i_flag_c ? (CW_IR_OUT | CW_PC_LOAD) : CW_NONE;
                        o_last_step = 1'b1;
                    end
                    OP_JZ: begin
                        o_ctrl      = i_flag_z ? (CW_IR_OUT | CW_PC_LOAD) : CW_NONE;
                        o_last_step = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl      = CW_A_OUT | CW_OUT_IN;
                        o_last_step = 1'b1;
                    end
                    OP_HLT:  o_halt_req  = 1'b1;
                    default: o_last_step = 1'b1;
                endcase
            end
            STEP_T3: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl      = CW_RAM_OUT | CW_A_IN;
                        o_last_step = 1'b1;
                    end
                    OP_ADD, OP_SUB: o_ctrl = CW_RAM_OUT | CW_B_IN;
                    OP_STA: begin
                        o_ctrl      = CW_A_OUT | CW_RAM_IN;
                        o_last_step = 1'b1;
                    end
                    default: o_last_step = 1'b1;
                endcase
            end
            STEP_T4: begin
                o_last_step = 1'b1;
                case (i_opcode)
                    OP_ADD: begin
                        o_ctrl    = CW_ALU_READ | CW_A_IN | CW_ALU_FLAGS;
                        o_flag_we = 1'b1;
                    end
                    OP_SUB: begin
                        o_ctrl    = CW_ALU_READ | CW_A_IN | CW_ALU_FLAGS | CW_ALU_SUB;
                        o_flag_we = 1'b1;
                    end
                    default: o_ctrl = CW_NONE;
                endcase
            end
            default: o_last_step = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Microcoded control unit: step counter, HALT state, latched
//                ALU flags and enable/reset gating of the datapath strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int DATA_W   = 8
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    control_sequencer_if.master  bus
);

    step_t               r_step_q;
    step_t               w_step_d;
    logic                r_halt_q;
    logic                w_halt_d;
    logic                r_flag_c_q;
    logic                w_flag_c_d;
    logic                r_flag_z_q;
    logic                w_flag_z_d;

    logic [OPCODE_W-1:0] w_opcode;
    ctrl_word_t          w_ctrl_raw;
    ctrl_word_t          w_ctrl;
    logic                w_last_step;
    logic                w_halt_req;
    logic                w_flag_we;
    logic                w_advance;
    logic                w_unused_instr_low;

    assign w_opcode           = bus.i_instr[DATA_W-1 -: OPCODE_W];
    assign w_unused_instr_low = ^bus.i_instr[DATA_W-OPCODE_W-1:0];

    control_sequencer_microcode_rom #(
        .OPCODE_W (OPCODE_W)
    ) u_rom (
        .i_opcode    (w_opcode),
        .i_step      (r_step_q),
        .i_flag_c    (r_flag_c_q),
        .i_flag_z    (r_flag_z_q),
        .o_ctrl      (w_ctrl_raw),
        .o_last_step (w_last_step),
        .o_halt_req  (w_halt_req),
        .o_flag_we   (w_flag_we)
    );

    assign w_advance = bus.i_step_en & ~r_halt_q;

    always_comb begin
        w_step_d   = r_step_q;
        w_halt_d   = r_halt_q;
        w_flag_c_d = r_flag_c_q;
        w_flag_z_d = r_flag_z_q;
        if (w_advance) begin
            // HLT freezes the step at T2; only reset leaves the HALT state.
            if (w_halt_req) begin
                w_halt_d = 1'b1;
            end else if (w_last_step) begin
                w_step_d = STEP_T0;
            end else begin
                w_step_d = step_t'(r_step_q + 3'd1);
            end
            if (w_flag_we) begin
                w_flag_c_d = bus.i_flag_c;
                w_flag_z_d = bus.i_flag_z;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_step_q   <= STEP_T0;
            r_halt_q   <= 1'b0;
            r_flag_c_q <= 1'b0;
            r_flag_z_q <= 1'b0;
        end else begin
            r_step_q   <= w_step_d;
            r_halt_q   <= w_halt_d;
            r_flag_c_q <= w_flag_c_d;
            r_flag_z_q <= w_flag_z_d;
        end
    end

    // Reset is asynchronous, so it also masks the strobes directly.
    assign w_ctrl = (w_advance && !i_reset) ? w_ctrl_raw : CW_NONE;

    assign bus.o_pc_out_n    = ~cw_has(w_ctrl, CW_PC_OUT);
    assign bus.o_pc_inc      =  cw_has(w_ctrl, CW_PC_INC);
    assign bus.o_pc_load_n   = ~cw_has(w_ctrl, CW_PC_LOAD);
    assign bus.o_mar_in_n    = ~cw_has(w_ctrl, CW_MAR_IN);
    assign bus.o_ram_out_n   = ~cw_has(w_ctrl, CW_RAM_OUT);
    assign bus.o_ram_in_n    = ~cw_has(w_ctrl, CW_RAM_IN);
    assign bus.o_ir_in_n     = ~cw_has(w_ctrl, CW_IR_IN);
    assign bus.o_ir_out_n    = ~cw_has(w_ctrl, CW_IR_OUT);
    assign bus.o_a_in_n      = ~cw_has(w_ctrl, CW_A_IN);
    assign bus.o_a_out_n     = ~cw_has(w_ctrl, CW_A_OUT);
    assign bus.o_b_in_n      = ~cw_has(w_ctrl, CW_B_IN);
    assign bus.o_out_in_n    = ~cw_has(w_ctrl, CW_OUT_IN);
    assign bus.o_alu_read_n  = ~cw_has(w_ctrl, CW_ALU_READ);
    assign bus.o_alu_sub     =  cw_has(w_ctrl, CW_ALU_SUB);
    assign bus.o_alu_flags_n = ~cw_has(w_ctrl, CW_ALU_FLAGS);

    assign bus.o_flag_c = r_flag_c_q;
    assign bus.o_flag_z = r_flag_z_q;
    assign bus.o_halt   = r_halt_q;
    assign bus.o_step   = r_step_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer with a per-opcode
//                micro-program table as reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    // Strobe set, active-high: bit0 pc_out .. bit14 alu_flags
    localparam logic [14:0] PC_OUT = 15'h0001, PC_INC = 15'h0002, PC_LOAD = 15'h0004;
    localparam logic [14:0] MAR_IN = 15'h0008, RAM_OUT = 15'h0010, RAM_IN = 15'h0020;
    localparam logic [14:0] IR_IN = 15'h0040, IR_OUT = 15'h0080, A_IN = 15'h0100;
    localparam logic [14:0] A_OUT = 15'h0200, B_IN = 15'h0400, OUT_IN = 15'h0800;
    localparam logic [14:0] ALU_READ = 15'h1000, ALU_SUB = 15'h2000, ALU_FLAGS = 15'h4000;
    localparam logic [14:0] DRIVERS = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_READ;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_sequencer_if #(.DATA_W(8)) bus ();

    control_sequencer #(.OPCODE_W(4), .DATA_W(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] prog [16][5];
    int          prog_len [16];
    int          m_step;
    bit          m_c, m_z, m_halt;

    task automatic build_programs();
        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 5; t++) prog[op][t] = '0;
            prog[op][0] = PC_OUT | MAR_IN;
            prog[op][1] = RAM_OUT | IR_IN | PC_INC;
            prog_len[op] = 2;
        end
        prog[1][2] = IR_OUT | MAR_IN;  prog[1][3] = RAM_OUT | A_IN;  prog_len[1] = 4;
        for (int op = 2; op <= 3; op++) begin
            prog[op][2] = IR_OUT | MAR_IN;
            prog[op][3] = RAM_OUT | B_IN;
            prog[op][4] = ALU_READ | A_IN | ALU_FLAGS | ((op == 3) ? ALU_SUB : 15'h0);
            prog_len[op] = 5;
        end
        prog[4][2]  = IR_OUT | MAR_IN;  prog[4][3] = A_OUT | RAM_IN;  prog_len[4] = 4;
        prog[5][2]  = IR_OUT | A_IN;    prog_len[5]  = 3;
        prog[6][2]  = IR_OUT | PC_LOAD; prog_len[6]  = 3;
        prog[7][2]  = IR_OUT | PC_LOAD; prog_len[7]  = 3;
        prog[8][2]  = IR_OUT | PC_LOAD; prog_len[8]  = 3;
        prog[14][2] = A_OUT | OUT_IN;   prog_len[14] = 3;
        prog_len[15] = 3;
    endtask

    function automatic logic [14:0] observed();
        return {~bus.o_alu_flags_n, bus.o_alu_sub, ~bus.o_alu_read_n, ~bus.o_out_in_n,
                ~bus.o_b_in_n, ~bus.o_a_out_n, ~bus.o_a_in_n, ~bus.o_ir_out_n,
                ~bus.o_ir_in_n, ~bus.o_ram_in_n, ~bus.o_ram_out_n, ~bus.o_mar_in_n,
                ~bus.o_pc_load_n, bus.o_pc_inc, ~bus.o_pc_out_n};
    endfunction

    function automatic logic [14:0] expected();
        int op;
        logic [14:0] m;
        op = int'(bus.i_instr[7:4]);
        if (rst || m_halt || !bus.i_step_en) return '0;
        m = prog[op][m_step];
        if (m_step == 2 && ((op == 7 && !m_c) || (op == 8 && !m_z))) m = '0;
        return m;
    endfunction

    task automatic model_reset();
        m_step = 0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
    endtask

    // One clock: model follows the posedge, then settle past the negedge.
    task automatic step_clk();
        int op;
        @(posedge clk);
        op = int'(bus.i_instr[7:4]);
        if (!rst && !m_halt && bus.i_step_en) begin
            if (op == 15 && m_step == 2) begin
                m_halt = 1'b1;
            end else begin
                if ((op == 2 || op == 3) && m_step == 4) begin
                    m_c = bus.i_flag_c;
                    m_z = bus.i_flag_z;
                end
                m_step = (m_step + 1 == prog_len[op]) ? 0 : m_step + 1;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.i_step_en = 1'b1; bus.i_instr = 8'h00;
        bus.i_flag_c = 1'b0; bus.i_flag_z = 1'b0;
        model_reset();
        repeat (2) step_clk();
        n_checks++;
        if (observed() !== 15'h0) begin
            n_fail++; $display("FAIL reset_strobes: got %h want 0000", observed());
        end
        n_checks++;
        if ({bus.o_step, bus.o_halt, bus.o_flag_c, bus.o_flag_z} !== 6'b0) begin
            n_fail++; $display("FAIL reset_state: got step=%0d halt=%b c=%b z=%b want all 0",
                               bus.o_step, bus.o_halt, bus.o_flag_c, bus.o_flag_z);
        end
        rst = 1'b0; #1;
        n_checks++;
        if (observed() !== (PC_OUT | MAR_IN)) begin
            n_fail++; $display("FAIL reset_release_t0: got %h want %h", observed(), PC_OUT | MAR_IN);
        end
    endtask

    task automatic test_reset_mid_add();
        bus.i_instr = 8'h2E;
        repeat (3) step_clk();
        n_checks++;
        if (bus.o_step !== 3'd3 || observed() !== (RAM_OUT | B_IN)) begin
            n_fail++; $display("FAIL add_t3: got step=%0d strobes=%h want 3 %h", bus.o_step, observed(), RAM_OUT | B_IN);
        end
        rst = 1'b1; model_reset(); #1;
        n_checks++;
        if (observed() !== 15'h0 || bus.o_step !== 3'd0) begin
            n_fail++; $display("FAIL abort_reset: got step=%0d strobes=%h want 0 0000", bus.o_step, observed());
        end
        step_clk();
        rst = 1'b0; #1;
        n_checks++;
        if (bus.o_step !== 3'd0 || observed() !== (PC_OUT | MAR_IN) || bus.o_flag_c !== 1'b0 || bus.o_flag_z !== 1'b0) begin
            n_fail++; $display("FAIL abort_release: got step=%0d strobes=%h c=%b z=%b want 0 %h 0 0",
                               bus.o_step, observed(), bus.o_flag_c, bus.o_flag_z, PC_OUT | MAR_IN);
        end
    endtask

    task automatic test_lda();
        logic [14:0] want [5];
        want[0] = PC_OUT | MAR_IN; want[1] = RAM_OUT | IR_IN | PC_INC;
        want[2] = IR_OUT | MAR_IN; want[3] = RAM_OUT | A_IN; want[4] = PC_OUT | MAR_IN;
        bus.i_instr = 8'h1E;
        for (int t = 0; t < 5; t++) begin
            n_checks++;
            if (observed() !== want[t] || bus.o_step !== 3'((t == 4) ? 0 : t)) begin
                n_fail++; $display("FAIL lda_cycle%0d: got step=%0d strobes=%h want %h", t, bus.o_step, observed(), want[t]);
            end
            if (t < 4) step_clk();
        end
    endtask

    task automatic test_sub_jumps();
        bus.i_instr = 8'h3F;
        repeat (4) step_clk();
        bus.i_flag_z = 1'b1; bus.i_flag_c = 1'b0; #1;
        n_checks++;
        if (observed() !== (ALU_READ | A_IN | ALU_FLAGS | ALU_SUB)) begin
            n_fail++; $display("FAIL sub_t4: got %h want %h", observed(), ALU_READ | A_IN | ALU_FLAGS | ALU_SUB);
        end
        step_clk();
        bus.i_flag_z = 1'b0; bus.i_flag_c = 1'b1;
        n_checks++;
        if (bus.o_flag_z !== 1'b1 || bus.o_flag_c !== 1'b0 || bus.o_step !== 3'd0) begin
            n_fail++; $display("FAIL sub_flags: got z=%b c=%b step=%0d want 1 0 0", bus.o_flag_z, bus.o_flag_c, bus.o_step);
        end
        bus.i_instr = 8'h85;
        repeat (2) step_clk();
        n_checks++;
        if (observed() !== (IR_OUT | PC_LOAD)) begin
            n_fail++; $display("FAIL jz_taken: got %h want %h", observed(), IR_OUT | PC_LOAD);
        end
        step_clk();
        bus.i_instr = 8'h75;
        repeat (2) step_clk();
        n_checks++;
        if (observed() !== 15'h0 || bus.o_step !== 3'd2) begin
            n_fail++; $display("FAIL jc_not_taken: got step=%0d strobes=%h want 2 0000", bus.o_step, observed());
        end
        step_clk();
        n_checks++;
        if (bus.o_step !== 3'd0) begin
            n_fail++; $display("FAIL jc_return_t0: got step=%0d want 0", bus.o_step);
        end
    endtask

    task automatic test_halt();
        bus.i_instr = 8'hF0;
        repeat (2) step_clk();
        n_checks++;
        if (observed() !== 15'h0 || bus.o_step !== 3'd2) begin
            n_fail++; $display("FAIL hlt_t2: got step=%0d strobes=%h want 2 0000", bus.o_step, observed());
        end
        for (int i = 0; i < 20; i++) begin
            step_clk();
            n_checks++;
            if (bus.o_halt !== 1'b1 || observed() !== 15'h0 || bus.o_step !== 3'd2) begin
                n_fail++; $display("FAIL halted_cycle%0d: got halt=%b step=%0d strobes=%h want 1 2 0000",
                                   i, bus.o_halt, bus.o_step, observed());
            end
        end
        rst = 1'b1; model_reset();
        step_clk();
        rst = 1'b0; #1;
        n_checks++;
        if (bus.o_halt !== 1'b0 || bus.o_step !== 3'd0 || observed() !== (PC_OUT | MAR_IN)) begin
            n_fail++; $display("FAIL halt_exit: got halt=%b step=%0d strobes=%h want 0 0 %h",
                               bus.o_halt, bus.o_step, observed(), PC_OUT | MAR_IN);
        end
    endtask

    task automatic test_stall();
        bus.i_instr = 8'h4A;
        repeat (3) step_clk();
        n_checks++;
        if (observed() !== (A_OUT | RAM_IN)) begin
            n_fail++; $display("FAIL sta_t3: got %h want %h", observed(), A_OUT | RAM_IN);
        end
        bus.i_step_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (observed() !== 15'h0 || bus.o_step !== 3'd3) begin
                n_fail++; $display("FAIL stall_cycle%0d: got step=%0d strobes=%h want 3 0000", i, bus.o_step, observed());
            end
            step_clk();
        end
        bus.i_step_en = 1'b1; #1;
        n_checks++;
        if (observed() !== (A_OUT | RAM_IN) || bus.o_step !== 3'd3) begin
            n_fail++; $display("FAIL stall_resume: got step=%0d strobes=%h want 3 %h", bus.o_step, observed(), A_OUT | RAM_IN);
        end
        step_clk();
        n_checks++;
        if (observed() !== (PC_OUT | MAR_IN) || bus.o_step !== 3'd0) begin
            n_fail++; $display("FAIL stall_once: got step=%0d strobes=%h want 0 %h", bus.o_step, observed(), PC_OUT | MAR_IN);
        end
    endtask

    task automatic test_nop();
        logic [7:0] ins [6];
        ins[0] = 8'h00; ins[1] = 8'h93; ins[2] = 8'hA7; ins[3] = 8'hB1; ins[4] = 8'hCC; ins[5] = 8'hD0;
        for (int k = 0; k < 6; k++) begin
            bus.i_instr = ins[k];
            step_clk();
            n_checks++;
            if (observed() !== (RAM_OUT | IR_IN | PC_INC) || bus.o_step !== 3'd1) begin
                n_fail++; $display("FAIL nop_t1_%h: got step=%0d strobes=%h", ins[k], bus.o_step, observed());
            end
            step_clk();
            n_checks++;
            if (observed() !== (PC_OUT | MAR_IN) || bus.o_step !== 3'd0) begin
                n_fail++; $display("FAIL nop_back_t0_%h: got step=%0d strobes=%h", ins[k], bus.o_step, observed());
            end
        end
    endtask

    task automatic test_random();
        int halted_for = 0;
        int op;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL rnd_strobes cyc%0d: got %h want %h (instr %h step %0d)",
                                   cyc, observed(), expected(), bus.i_instr, m_step);
            end
            n_checks++;
            if (bus.o_step !== 3'(m_step) || bus.o_halt !== m_halt || bus.o_flag_c !== m_c || bus.o_flag_z !== m_z) begin
                n_fail++; $display("FAIL rnd_state cyc%0d: got step=%0d halt=%b c=%b z=%b want %0d %b %b %b",
                                   cyc, bus.o_step, bus.o_halt, bus.o_flag_c, bus.o_flag_z, m_step, m_halt, m_c, m_z);
            end
            n_checks++;
            if ($countones(observed() & DRIVERS) > 1) begin
                n_fail++; $display("FAIL rnd_bus_drivers cyc%0d: got %h want at most one driver", cyc, observed() & DRIVERS);
            end
            bus.i_step_en = ($urandom_range(0, 7) != 0);
            bus.i_flag_c  = 1'($urandom_range(0, 1));
            bus.i_flag_z  = 1'($urandom_range(0, 1));
            if (m_step == 0 && !m_halt) begin
                op = int'($urandom_range(0, 15));
                if (op == 15 && $urandom_range(0, 3) != 0) op = int'($urandom_range(0, 14));
                bus.i_instr = {4'(op), 4'($urandom_range(0, 15))};
            end
            halted_for = m_halt ? halted_for + 1 : 0;
            if (halted_for > 4) begin
                rst = 1'b1; model_reset();
                step_clk();
                rst = 1'b0;
                halted_for = 0;
            end
            step_clk();
        end
    endtask

    initial begin
        build_programs();
        test_reset();
        test_reset_mid_add();
        test_lda();
        test_sub_jumps();
        test_halt();
        test_stall();
        test_nop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
